// File: rtl/order_book_pkg.sv
// Shared constants and types for the L2 order book.
// Holds op codes, side selects and the control FSM state type.
package order_book_pkg;

    localparam logic [1:0] OP_ADD = 2'd0;
    localparam logic [1:0] OP_DEL = 2'd1;
    localparam logic [1:0] OP_CLR = 2'd2;
    localparam logic [1:0] OP_NOP = 2'd3;

    localparam logic SIDE_BID = 1'b0;
    localparam logic SIDE_ASK = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_APPLY,
        ST_PUBLISH
    } state_t;

endpackage

// File: rtl/order_book_side.sv
// One side of the book: a sorted shift-register array of {price, qty}.
// Ports: clk, reset_n; apply/clear strobes with op, price, qty;
// top_price/top_qty/top_valid of index 0, depth, and the
// overflow/miss flags of the operation being applied this cycle.
module order_book_side
    import order_book_pkg::*;
#(
    parameter int LEVELS     = 8,
    parameter int PRICE_W    = 32,
    parameter int QTY_W      = 24,
    parameter int DESCENDING = 1
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic                          apply,
    input  logic                          clear,
    input  logic [1:0]                    op,
    input  logic [PRICE_W-1:0]            price,
    input  logic [QTY_W-1:0]              qty,
    output logic [PRICE_W-1:0]            top_price,
    output logic [QTY_W-1:0]              top_qty,
    output logic                          top_valid,
    output logic [$clog2(LEVELS+1)-1:0]   depth,
    output logic                          overflow,
    output logic                          miss
);

    localparam int IDX_W   = $clog2(LEVELS);
    localparam int DEPTH_W = $clog2(LEVELS+1);

    logic [PRICE_W-1:0] p_q  [LEVELS];
    logic [PRICE_W-1:0] p_d  [LEVELS];
    logic [PRICE_W-1:0] p_up [LEVELS];
    logic [PRICE_W-1:0] p_dn [LEVELS];
    logic [QTY_W-1:0]   q_q  [LEVELS];
    logic [QTY_W-1:0]   q_d  [LEVELS];
    logic [QTY_W-1:0]   q_up [LEVELS];
    logic [QTY_W-1:0]   q_dn [LEVELS];
    logic [LEVELS-1:0]  v_q;
    logic [LEVELS-1:0]  v_d;
    logic [LEVELS-1:0]  v_up;
    logic [LEVELS-1:0]  v_dn;
    logic [LEVELS-1:0]  match;
    logic [LEVELS-1:0]  better;
    logic [LEVELS-1:0]  prev_better;
    logic [IDX_W-1:0]   hit_idx;
    logic [QTY_W-1:0]   hit_qty;
    logic [QTY_W:0]     sum;
    logic               full;
    logic               seen;

    // Neighbour views: *_up[i] is entry i-1 (insert shift),
    // *_dn[i] is entry i+1 (remove shift).
    always_comb begin
        p_up[0] = '0;
        q_up[0] = '0;
        for (int i = 1; i < LEVELS; i++) begin
            p_up[i] = p_q[i-1];
            q_up[i] = q_q[i-1];
        end
        p_dn[LEVELS-1] = '0;
        q_dn[LEVELS-1] = '0;
        for (int i = 0; i < LEVELS-1; i++) begin
            p_dn[i] = p_q[i+1];
            q_dn[i] = q_q[i+1];
        end
    end

    assign v_up = {v_q[LEVELS-2:0], 1'b0};
    assign v_dn = {1'b0, v_q[LEVELS-1:1]};

    // better[i]: entry i outranks the incoming price. Because the
    // array is sorted and contiguous this is a prefix mask, so the
    // insert slot is the first index where it drops to zero.
    always_comb begin
        better = '0;
        match  = '0;
        for (int i = 0; i < LEVELS; i++) begin
            if (DESCENDING != 0) begin
                better[i] = v_q[i] && (p_q[i] > price);
            end else begin
                better[i] = v_q[i] && (p_q[i] < price);
            end
            match[i] = v_q[i] && (p_q[i] == price);
        end
    end

    assign prev_better = {better[LEVELS-2:0], 1'b1};
    assign full        = v_q[LEVELS-1];

    always_comb begin
        hit_idx = '0;
        hit_qty = '0;
        for (int i = 0; i < LEVELS; i++) begin
            if (match[i]) begin
                hit_idx = IDX_W'(i);
                hit_qty = q_q[i];
            end
        end
    end

    assign sum = {1'b0, hit_qty} + {1'b0, qty};

    always_comb begin
        p_d      = p_q;
        q_d      = q_q;
        v_d      = v_q;
        overflow = 1'b0;
        miss     = 1'b0;
        seen     = 1'b0;
        if (clear) begin
            v_d = '0;
            for (int i = 0; i < LEVELS; i++) begin
                p_d[i] = '0;
                q_d[i] = '0;
            end
        end else if (apply) begin
            case (op)
                OP_ADD: begin
                    if (qty != '0) begin
                        if (|match) begin
                            q_d[hit_idx] = sum[QTY_W] ?
                                {QTY_W{1'b1}} : sum[QTY_W-1:0];
                        end else begin
                            overflow = full;
                            // When full, the worst slot still
                            // outranking the price means no room.
                            if (!better[LEVELS-1]) begin
                                for (int i = 0; i < LEVELS; i++) begin
                                    if (!better[i]) begin
                                        if (prev_better[i]) begin
                                            p_d[i] = price;
                                            q_d[i] = qty;
                                            v_d[i] = 1'b1;
                                        end else begin
                                            p_d[i] = p_up[i];
                                            q_d[i] = q_up[i];
                                            v_d[i] = v_up[i];
                                        end
                                    end
                                end
                            end
                        end
                    end
                end
                OP_DEL: begin
                    if (!(|match)) begin
                        miss = 1'b1;
                    end else if (qty < hit_qty) begin
                        q_d[hit_idx] = hit_qty - qty;
                    end else begin
                        for (int i = 0; i < LEVELS; i++) begin
                            seen = seen | match[i];
                            if (seen) begin
                                p_d[i] = p_dn[i];
                                q_d[i] = q_dn[i];
                                v_d[i] = v_dn[i];
                            end
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            v_q <= '0;
            for (int i = 0; i < LEVELS; i++) begin
                p_q[i] <= '0;
                q_q[i] <= '0;
            end
        end else begin
            v_q <= v_d;
            p_q <= p_d;
            q_q <= q_d;
        end
    end

    always_comb begin
        depth = '0;
        for (int i = 0; i < LEVELS; i++) begin
            depth = depth + DEPTH_W'(v_q[i]);
        end
    end

    assign top_price = p_q[0];
    assign top_qty   = q_q[0];
    assign top_valid = v_q[0];

endmodule

// File: rtl/order_book_l2.sv
// Level-2 order book: bid and ask sorted level arrays, a 3-state
// message FSM and registered top-of-book outputs.
// Ports: msg_valid/msg_ready handshake with msg_op/side/price/qty;
// best_bid/ask (+qty), depths, tob_valid, crossed, overflow, miss.
module order_book_l2
    import order_book_pkg::*;
#(
    parameter int LEVELS  = 8,
    parameter int PRICE_W = 32,
    parameter int QTY_W   = 24
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic                          msg_valid,
    output logic                          msg_ready,
    input  logic [1:0]                    msg_op,
    input  logic                          msg_side,
    input  logic [PRICE_W-1:0]            msg_price,
    input  logic [QTY_W-1:0]              msg_qty,
    output logic [PRICE_W-1:0]            best_bid,
    output logic [QTY_W-1:0]              best_bid_qty,
    output logic [PRICE_W-1:0]            best_ask,
    output logic [QTY_W-1:0]              best_ask_qty,
    output logic [$clog2(LEVELS+1)-1:0]   bid_depth,
    output logic [$clog2(LEVELS+1)-1:0]   ask_depth,
    output logic                          tob_valid,
    output logic                          crossed,
    output logic                          overflow,
    output logic                          miss
);

    localparam int DEPTH_W = $clog2(LEVELS+1);

    state_t             state_q;
    state_t             state_d;
    logic               apply;
    logic               publish;
    logic               accept;
    logic [1:0]         op_q;
    logic               side_q;
    logic [PRICE_W-1:0] price_q;
    logic [QTY_W-1:0]   qty_q;
    logic               clr;
    logic               bid_apply;
    logic               ask_apply;
    logic [PRICE_W-1:0] bid_p;
    logic [QTY_W-1:0]   bid_q;
    logic               bid_v;
    logic [DEPTH_W-1:0] bid_d;
    logic               bid_ovf;
    logic               bid_miss;
    logic [PRICE_W-1:0] ask_p;
    logic [QTY_W-1:0]   ask_q;
    logic               ask_v;
    logic [DEPTH_W-1:0] ask_d;
    logic               ask_ovf;
    logic               ask_miss;
    logic               ovf_pend;
    logic               miss_pend;

    always_comb begin
        state_d   = state_q;
        msg_ready = 1'b0;
        apply     = 1'b0;
        publish   = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                msg_ready = 1'b1;
                if (msg_valid) state_d = ST_APPLY;
            end
            ST_APPLY: begin
                apply   = 1'b1;
                state_d = ST_PUBLISH;
            end
            ST_PUBLISH: begin
                publish = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) state_q <= ST_IDLE;
        else          state_q <= state_d;
    end

    assign accept = msg_valid && msg_ready;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            op_q    <= OP_NOP;
            side_q  <= SIDE_BID;
            price_q <= '0;
            qty_q   <= '0;
        end else if (accept) begin
            op_q    <= msg_op;
            side_q  <= msg_side;
            price_q <= msg_price;
            qty_q   <= msg_qty;
        end
    end

    assign clr       = apply && (op_q == OP_CLR);
    assign bid_apply = apply && (side_q == SIDE_BID);
    assign ask_apply = apply && (side_q == SIDE_ASK);

    order_book_side #(
        .LEVELS     (LEVELS),
        .PRICE_W    (PRICE_W),
        .QTY_W      (QTY_W),
        .DESCENDING (1)
    ) u_bid (
        .clk       (clk),
        .reset_n   (reset_n),
        .apply     (bid_apply),
        .clear     (clr),
        .op        (op_q),
        .price     (price_q),
        .qty       (qty_q),
        .top_price (bid_p),
        .top_qty   (bid_q),
        .top_valid (bid_v),
        .depth     (bid_d),
        .overflow  (bid_ovf),
        .miss      (bid_miss)
    );

    order_book_side #(
        .LEVELS     (LEVELS),
        .PRICE_W    (PRICE_W),
        .QTY_W      (QTY_W),
        .DESCENDING (0)
    ) u_ask (
        .clk       (clk),
        .reset_n   (reset_n),
        .apply     (ask_apply),
        .clear     (clr),
        .op        (op_q),
        .price     (price_q),
        .qty       (qty_q),
        .top_price (ask_p),
        .top_qty   (ask_q),
        .top_valid (ask_v),
        .depth     (ask_d),
        .overflow  (ask_ovf),
        .miss      (ask_miss)
    );

    // Error flags are caught as the arrays update, then released
    // one cycle later together with the refreshed top of book.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            ovf_pend  <= 1'b0;
            miss_pend <= 1'b0;
        end else if (apply) begin
            ovf_pend  <= bid_ovf | ask_ovf;
            miss_pend <= bid_miss | ask_miss;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            best_bid     <= '0;
            best_bid_qty <= '0;
            best_ask     <= '1;
            best_ask_qty <= '0;
            bid_depth    <= '0;
            ask_depth    <= '0;
            tob_valid    <= 1'b0;
            crossed      <= 1'b0;
            overflow     <= 1'b0;
            miss         <= 1'b0;
        end else begin
            tob_valid <= publish;
            overflow  <= publish && ovf_pend;
            miss      <= publish && miss_pend;
            if (publish) begin
                best_bid     <= bid_v ? bid_p : '0;
                best_bid_qty <= bid_v ? bid_q : '0;
                best_ask     <= ask_v ? ask_p : '1;
                best_ask_qty <= ask_v ? ask_q : '0;
                bid_depth    <= bid_d;
                ask_depth    <= ask_d;
                crossed      <= bid_v && ask_v && (bid_p >= ask_p);
            end
        end
    end

endmodule

// File: tb/tb_order_book_l2.sv
// Self-checking bench for order_book_l2 (default parameters).
// A reference book predicts each top-of-book pulse.
module tb_order_book_l2;
    import order_book_pkg::*;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        msg_valid;
    logic        msg_ready;
    logic [1:0]  msg_op;
    logic        msg_side;
    logic [31:0] msg_price;
    logic [23:0] msg_qty;
    logic [31:0] best_bid;
    logic [23:0] best_bid_qty;
    logic [31:0] best_ask;
    logic [23:0] best_ask_qty;
    logic [3:0]  bid_depth;
    logic [3:0]  ask_depth;
    logic        tob_valid;
    logic        crossed;
    logic        overflow;
    logic        miss;

    always #5 clk = ~clk;

    order_book_l2 dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .msg_valid    (msg_valid),
        .msg_ready    (msg_ready),
        .msg_op       (msg_op),
        .msg_side     (msg_side),
        .msg_price    (msg_price),
        .msg_qty      (msg_qty),
        .best_bid     (best_bid),
        .best_bid_qty (best_bid_qty),
        .best_ask     (best_ask),
        .best_ask_qty (best_ask_qty),
        .bid_depth    (bid_depth),
        .ask_depth    (ask_depth),
        .tob_valid    (tob_valid),
        .crossed      (crossed),
        .overflow     (overflow),
        .miss         (miss)
    );

    typedef struct packed {
        logic [31:0] bb;
        logic [23:0] bbq;
        logic [31:0] ba;
        logic [23:0] baq;
        logic [3:0]  bd;
        logic [3:0]  ad;
        logic        cr;
        logic        ov;
        logic        mi;
    } tob_t;

    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;
    tob_t exp_q[$];
    int   due_q[$];

    logic [31:0] mp [2][8];
    logic [23:0] mq [2][8];
    int          md [2];

    always @(posedge clk) cyc++;

    function automatic logic mbetter(int s, logic [31:0] a,
                                     logic [31:0] b);
        return (s == 0) ? (a > b) : (a < b);
    endfunction

    task automatic model_apply(input logic [1:0] op, input logic side,
                               input logic [31:0] price,
                               input logic [23:0] qty, input int due);
        int          s;
        int          k;
        int          pos;
        logic        ov;
        logic        mi;
        logic [24:0] sum;
        tob_t        t;
        s  = side ? 1 : 0;
        k  = -1;
        ov = 1'b0;
        mi = 1'b0;
        for (int i = 0; i < md[s]; i++)
            if (mp[s][i] == price) k = i;
        case (op)
            OP_ADD: if (qty != 0) begin
                if (k >= 0) begin
                    sum = {1'b0, mq[s][k]} + {1'b0, qty};
                    mq[s][k] = sum[24] ? 24'hFFFFFF : sum[23:0];
                end else begin
                    pos = md[s];
                    for (int i = md[s] - 1; i >= 0; i--)
                        if (!mbetter(s, mp[s][i], price)) pos = i;
                    if (md[s] == 8) begin
                        ov = 1'b1;
                        if (pos < 8) begin
                            for (int i = 7; i > pos; i--) begin
                                mp[s][i] = mp[s][i-1];
                                mq[s][i] = mq[s][i-1];
                            end
                            mp[s][pos] = price;
                            mq[s][pos] = qty;
                        end
                    end else begin
                        for (int i = md[s]; i > pos; i--) begin
                            mp[s][i] = mp[s][i-1];
                            mq[s][i] = mq[s][i-1];
                        end
                        mp[s][pos] = price;
                        mq[s][pos] = qty;
                        md[s]++;
                    end
                end
            end
            OP_DEL: begin
                if (k < 0) begin
                    mi = 1'b1;
                end else if (qty < mq[s][k]) begin
                    mq[s][k] = mq[s][k] - qty;
                end else begin
                    for (int i = k; i < md[s] - 1; i++) begin
                        mp[s][i] = mp[s][i+1];
                        mq[s][i] = mq[s][i+1];
                    end
                    md[s]--;
                end
            end
            OP_CLR: begin
                md[0] = 0;
                md[1] = 0;
            end
            default: begin
            end
        endcase
        t.bb  = (md[0] > 0) ? mp[0][0] : 32'd0;
        t.bbq = (md[0] > 0) ? mq[0][0] : 24'd0;
        t.ba  = (md[1] > 0) ? mp[1][0] : 32'hFFFFFFFF;
        t.baq = (md[1] > 0) ? mq[1][0] : 24'd0;
        t.bd  = 4'(md[0]);
        t.ad  = 4'(md[1]);
        t.cr  = (md[0] > 0) && (md[1] > 0) && (mp[0][0] >= mp[1][0]);
        t.ov  = ov;
        t.mi  = mi;
        exp_q.push_back(t);
        due_q.push_back(due);
    endtask

    always @(negedge clk) begin
        tob_t got;
        tob_t e;
        int   d;
        if (reset_n === 1'b1 && tob_valid === 1'b1) begin
            got = {best_bid, best_bid_qty, best_ask, best_ask_qty,
                   bid_depth, ask_depth, crossed, overflow, miss};
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL tob_unexpected: pulse at cycle %0d, none due",
                         cyc);
            end else begin
                e = exp_q.pop_front();
                d = due_q.pop_front();
                if (got !== e) begin
                    bad++;
                    $display({"FAIL tob: got bb=%0d bbq=%0d ba=%h baq=%0d",
                              " bd=%0d ad=%0d cr=%b ov=%b mi=%b;",
                              " required bb=%0d bbq=%0d ba=%h baq=%0d",
                              " bd=%0d ad=%0d cr=%b ov=%b mi=%b"},
                             got.bb, got.bbq, got.ba, got.baq, got.bd,
                             got.ad, got.cr, got.ov, got.mi,
                             e.bb, e.bbq, e.ba, e.baq, e.bd,
                             e.ad, e.cr, e.ov, e.mi);
                end
                total++;
                if (cyc !== d) begin
                    bad++;
                    $display("FAIL tob_latency: cycle=%0d required=%0d",
                             cyc, d);
                end
            end
        end
    end

    task automatic send(input logic [1:0] op, input logic side,
                        input logic [31:0] price, input logic [23:0] qty);
        int n;
        n = 0;
        @(negedge clk);
        msg_op    = op;
        msg_side  = side;
        msg_price = price;
        msg_qty   = qty;
        msg_valid = 1'b1;
        while (msg_ready !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (msg_ready !== 1'b1) begin
            total++;
            bad++;
            $display("FAIL accept_timeout: msg_ready=%b required=1",
                     msg_ready);
            msg_valid = 1'b0;
            return;
        end
        model_apply(op, side, price, qty, cyc + 3);
        @(negedge clk);
        msg_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
    endtask

    task automatic model_clear();
        md[0] = 0;
        md[1] = 0;
        exp_q.delete();
        due_q.delete();
    endtask

    task automatic test_reset();
        reset_n   = 1'b0;
        msg_valid = 1'b0;
        msg_op    = OP_NOP;
        msg_side  = SIDE_BID;
        msg_price = '0;
        msg_qty   = '0;
        model_clear();
        repeat (3) @(negedge clk);
        total++;
        if ({best_bid, best_bid_qty, best_ask_qty, bid_depth, ask_depth}
            !== '0 || best_ask !== 32'hFFFFFFFF) begin
            bad++;
            $display("FAIL reset_book: bb=%0d ba=%h bd=%0d ad=%0d required 0/ffffffff/0/0",
                     best_bid, best_ask, bid_depth, ask_depth);
        end
        total++;
        if ({tob_valid, crossed, overflow, miss} !== 4'b0) begin
            bad++;
            $display("FAIL reset_flags: got=%b required=0000",
                     {tob_valid, crossed, overflow, miss});
        end
        reset_n = 1'b1;
        @(negedge clk);
        total++;
        if (msg_ready !== 1'b1) begin
            bad++;
            $display("FAIL reset_ready: got=%b required=1", msg_ready);
        end
    endtask

    task automatic test_add_sort();
        send(OP_ADD, SIDE_BID, 100, 5);
        send(OP_ADD, SIDE_BID, 102, 3);
        send(OP_ADD, SIDE_BID, 101, 7);
        total++;
        if (best_bid !== 32'd102 || best_bid_qty !== 24'd3 ||
            bid_depth !== 4'd3) begin
            bad++;
            $display("FAIL add_sort: bb=%0d q=%0d d=%0d required 102/3/3",
                     best_bid, best_bid_qty, bid_depth);
        end
        send(OP_DEL, SIDE_BID, 102, 3);
        total++;
        if (best_bid !== 32'd101 || best_bid_qty !== 24'd7) begin
            bad++;
            $display("FAIL add_sort_2nd: bb=%0d q=%0d required 101/7",
                     best_bid, best_bid_qty);
        end
        send(OP_DEL, SIDE_BID, 101, 7);
        total++;
        if (best_bid !== 32'd100 || bid_depth !== 4'd1) begin
            bad++;
            $display("FAIL add_sort_3rd: bb=%0d d=%0d required 100/1",
                     best_bid, bid_depth);
        end
    endtask

    task automatic test_add_merge();
        send(OP_ADD, SIDE_ASK, 105, 4);
        send(OP_ADD, SIDE_ASK, 107, 2);
        send(OP_ADD, SIDE_ASK, 105, 6);
        total++;
        if (best_ask !== 32'd105 || best_ask_qty !== 24'd10 ||
            ask_depth !== 4'd2) begin
            bad++;
            $display("FAIL add_merge: ba=%0d q=%0d d=%0d required 105/10/2",
                     best_ask, best_ask_qty, ask_depth);
        end
        send(OP_ADD, SIDE_ASK, 105, 24'hFFFFFF);
        total++;
        if (best_ask_qty !== 24'hFFFFFF) begin
            bad++;
            $display("FAIL add_saturate: q=%h required ffffff",
                     best_ask_qty);
        end
    endtask

    task automatic test_delete();
        send(OP_CLR, SIDE_ASK, 0, 0);
        send(OP_ADD, SIDE_BID, 102, 3);
        send(OP_ADD, SIDE_BID, 101, 7);
        send(OP_DEL, SIDE_BID, 102, 1);
        total++;
        if (best_bid_qty !== 24'd2) begin
            bad++;
            $display("FAIL del_partial: q=%0d required 2", best_bid_qty);
        end
        send(OP_DEL, SIDE_BID, 102, 5);
        total++;
        if (best_bid !== 32'd101 || bid_depth !== 4'd1) begin
            bad++;
            $display("FAIL del_remove: bb=%0d d=%0d required 101/1",
                     best_bid, bid_depth);
        end
        send(OP_DEL, SIDE_BID, 99, 1);
        total++;
        if (miss !== 1'b1 || best_bid !== 32'd101 ||
            best_bid_qty !== 24'd7) begin
            bad++;
            $display("FAIL del_miss: miss=%b bb=%0d q=%0d required 1/101/7",
                     miss, best_bid, best_bid_qty);
        end
    endtask

    task automatic test_crossed();
        send(OP_CLR, SIDE_BID, 0, 0);
        send(OP_ADD, SIDE_ASK, 105, 4);
        send(OP_ADD, SIDE_BID, 105, 1);
        total++;
        if (crossed !== 1'b1) begin
            bad++;
            $display("FAIL crossed_equal: got=%b required=1", crossed);
        end
        send(OP_DEL, SIDE_BID, 105, 1);
        send(OP_ADD, SIDE_BID, 104, 1);
        total++;
        if (crossed !== 1'b0) begin
            bad++;
            $display("FAIL crossed_below: got=%b required=0", crossed);
        end
        send(OP_ADD, SIDE_BID, 106, 1);
        total++;
        if (crossed !== 1'b1) begin
            bad++;
            $display("FAIL crossed_above: got=%b required=1", crossed);
        end
        send(OP_CLR, SIDE_ASK, 0, 0);
        total++;
        if (bid_depth !== 4'd0 || ask_depth !== 4'd0 ||
            best_bid !== 32'd0 || best_ask !== 32'hFFFFFFFF ||
            crossed !== 1'b0) begin
            bad++;
            $display("FAIL clr: bd=%0d ad=%0d bb=%0d ba=%h cr=%b required 0/0/0/ffffffff/0",
                     bid_depth, ask_depth, best_bid, best_ask, crossed);
        end
    endtask

    task automatic test_overflow();
        for (int p = 1; p <= 8; p++) send(OP_ADD, SIDE_BID, 32'(p), 1);
        send(OP_ADD, SIDE_BID, 0, 1);
        total++;
        if (overflow !== 1'b1 || best_bid !== 32'd8 ||
            bid_depth !== 4'd8) begin
            bad++;
            $display("FAIL ovf_reject: ovf=%b bb=%0d d=%0d required 1/8/8",
                     overflow, best_bid, bid_depth);
        end
        send(OP_ADD, SIDE_BID, 9, 1);
        total++;
        if (overflow !== 1'b1 || best_bid !== 32'd9 ||
            bid_depth !== 4'd8) begin
            bad++;
            $display("FAIL ovf_insert: ovf=%b bb=%0d d=%0d required 1/9/8",
                     overflow, best_bid, bid_depth);
        end
        send(OP_DEL, SIDE_BID, 1, 1);
        total++;
        if (miss !== 1'b1) begin
            bad++;
            $display("FAIL ovf_discard: miss=%b required 1", miss);
        end
    endtask

    task automatic test_nop_zero();
        send(OP_ADD, SIDE_BID, 3, 0);
        total++;
        if (overflow !== 1'b0 || miss !== 1'b0 || bid_depth !== 4'd8) begin
            bad++;
            $display("FAIL add_zero: ovf=%b miss=%b d=%0d required 0/0/8",
                     overflow, miss, bid_depth);
        end
        send(OP_NOP, SIDE_ASK, 7, 7);
        total++;
        if (tob_valid !== 1'b1 || best_bid !== 32'd9) begin
            bad++;
            $display("FAIL nop: tob=%b bb=%0d required 1/9",
                     tob_valid, best_bid);
        end
    endtask

    task automatic test_reset_abort();
        int acc;
        @(negedge clk);
        msg_op    = OP_ADD;
        msg_side  = SIDE_BID;
        msg_price = 200;
        msg_qty   = 9;
        msg_valid = 1'b1;
        @(negedge clk);
        msg_valid = 1'b0;
        reset_n   = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        model_clear();
        total++;
        if (msg_ready !== 1'b1 || best_bid !== 32'd0 ||
            bid_depth !== 4'd0) begin
            bad++;
            $display("FAIL abort: ready=%b bb=%0d d=%0d required 1/0/0",
                     msg_ready, best_bid, bid_depth);
        end
        repeat (3) @(negedge clk);
        total++;
        if (best_bid !== 32'd0 || bid_depth !== 4'd0) begin
            bad++;
            $display("FAIL abort_late: bb=%0d d=%0d required 0/0",
                     best_bid, bid_depth);
        end
        msg_op    = OP_ADD;
        msg_side  = SIDE_BID;
        msg_price = 50;
        msg_qty   = 2;
        msg_valid = 1'b1;
        acc       = 0;
        for (int i = 0; i < 3; i++) begin
            if (msg_ready === 1'b1) begin
                acc++;
                if (acc == 1) model_apply(OP_ADD, SIDE_BID, 50, 2, cyc + 3);
            end
            @(negedge clk);
        end
        msg_valid = 1'b0;
        total++;
        if (acc !== 1) begin
            bad++;
            $display("FAIL hold_once: accepts=%0d required=1", acc);
        end
        total++;
        if (best_bid !== 32'd50 || best_bid_qty !== 24'd2) begin
            bad++;
            $display("FAIL hold_result: bb=%0d q=%0d required 50/2",
                     best_bid, best_bid_qty);
        end
        @(negedge clk);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_add_sort();
        test_add_merge();
        test_delete();
        test_crossed();
        test_overflow();
        test_nop_zero();
        test_reset_abort();
        repeat (4) @(negedge clk);
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL pending: %0d results never seen, required 0",
                     exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/order_book_l2.md
ORDER_BOOK_L2 -- requirements
Module: order_book_l2

Interface
REQ-001 Parameter LEVELS, default 8, price levels held per side (2..32).
REQ-002 Parameter PRICE_W, default 32, price width in ticks (unsigned).
REQ-003 Parameter QTY_W, default 24, quantity width (unsigned).
REQ-004 Port clk, input, 1, single clock; all logic SHALL be on its rising edge.
REQ-005 Port reset_n, input, 1, reset; synchronous, active-low.
REQ-006 Port msg_valid, input, 1, update message present.
REQ-007 Port msg_ready, output, 1, block accepts a message this cycle.
REQ-008 Port msg_op, input, 2, operation code: ADD=0, DEL=1, CLR=2, NOP=3.
REQ-009 Port msg_side, input, 1, side select: 0=bid, 1=ask.
REQ-010 Port msg_price, input, PRICE_W, level price.
REQ-011 Port msg_qty, input, QTY_W, quantity delta.
REQ-012 Port best_bid / best_bid_qty, output, PRICE_W / QTY_W, top bid level.
REQ-013 Port best_ask / best_ask_qty, output, PRICE_W / QTY_W, top ask level.
REQ-014 Port bid_depth / ask_depth, output, $clog2(LEVELS+1), occupied levels per side.
REQ-015 Port tob_valid, output, 1, one-cycle pulse: top-of-book outputs refreshed.
REQ-016 Port crossed, output, 1, registered flag: both sides non-empty and best_bid >= best_ask.
REQ-017 Port overflow / miss, output, 1 each, one-cycle error pulses aligned with tob_valid.

Function
REQ-018 Each side SHALL hold a sorted array of {price, qty} entries: bids strictly descending, asks strictly ascending, with no duplicate prices and occupied entries contiguous from index 0.
REQ-019 The FSM SHALL have states IDLE, APPLY and PUBLISH; msg_ready=1 only in IDLE; a message is accepted when msg_valid&&msg_ready.
REQ-020 Transitions: IDLE->APPLY on accept; APPLY->PUBLISH always; PUBLISH->IDLE always.
REQ-021 Latency: a message accepted at edge N SHALL update the arrays at N+1, and the outputs SHALL update with tob_valid=1 at N+2; maximum throughput is one message per 3 cycles.
REQ-022 NOP SHALL traverse the FSM, change no state and still pulse tob_valid.
REQ-023 ADD, price present: qty SHALL become qty+msg_qty, saturating at 2^QTY_W-1.
REQ-024 ADD, price absent, side not full: the entry SHALL be inserted at its sorted position, worse levels shift down one index, depth+1.
REQ-025 ADD, price absent, side full, price better than the worst level: insert as above, discard the worst level, depth unchanged, overflow pulsed.
REQ-026 ADD, price absent, side full, price equal to or worse than the worst level: book unchanged, overflow pulsed.
REQ-027 ADD with msg_qty=0: no state change, no error.
REQ-028 DEL, price present, msg_qty < level qty: qty SHALL decrease by msg_qty.
REQ-029 DEL, price present, msg_qty >= level qty: the level SHALL be removed, worse levels shift up one index, depth-1.
REQ-030 DEL, price absent: book unchanged, miss pulsed.
REQ-031 CLR SHALL empty both sides irrespective of msg_side.
REQ-032 Empty bid side: best_bid=0, best_bid_qty=0. Empty ask side: best_ask=all ones, best_ask_qty=0.
REQ-033 msg_valid while msg_ready=0 SHALL be ignored; the upstream must hold the message.

Reset
REQ-034 While reset_n=0 at a rising edge: FSM->IDLE; all entries invalid; depths 0; best_bid=0; best_ask=all ones; all quantities 0; tob_valid, crossed, overflow and miss 0.
REQ-035 Reset asserted in APPLY or PUBLISH SHALL abort the in-flight message with no partial update; msg_ready=1 on the first cycle after release.

Structure
REQ-036 Package order_book_pkg SHALL hold the op-code constants (OP_ADD, OP_DEL, OP_CLR, OP_NOP) and the side constants (SIDE_BID, SIDE_ASK).
REQ-037 Sub-module order_book_side SHALL be instanced twice, with parameter DESCENDING=1 for bids and 0 for asks; it implements the per-entry compare, match, insert and remove logic as a shift-register array.
REQ-038 Top level SHALL hold the FSM, message capture registers, output registers and the crossed comparator.

Verification
REQ-039 After reset: ADD bid 100/5, ADD bid 102/3, ADD bid 101/7 -> bid order 102,101,100; best_bid=102, best_bid_qty=3, bid_depth=3, each tob_valid 2 cycles after accept.
REQ-040 ADD ask 105/4, then ADD ask 105/6 -> best_ask_qty=10, ask_depth=1; ADD ask 105 with qty=2^24-1 -> qty saturates at 2^24-1.
REQ-041 Fill bids 1..8 (LEVELS=8), ADD bid 0 -> overflow pulse, book unchanged; ADD bid 9 -> best_bid=9, bid 1 discarded, overflow pulse, bid_depth=8.
REQ-042 Bids {102/3,101/7}: DEL 102/1 -> qty 2; DEL 102/5 -> level removed, best_bid=101; DEL 99/1 -> miss pulse, book unchanged.
REQ-043 ADD bid 106 with best_ask=105 -> crossed=1; CLR -> depths 0, best_bid=0, best_ask=FFFFFFFF, crossed=0.
REQ-044 Reset asserted in the APPLY cycle of ADD bid 200 -> after release best_bid=0, depth 0, msg_ready=1, and a msg_valid held during busy cycles is accepted exactly once.
